pc_fetch_unit: RTL and testbench

Program counter, 8-level hardware return stack and instruction register for the PIC16F core. It sits directly upstream of the instruction decoder and acts on that decoder's PC and fetch controls. It drives the program-memory address, latches the returned word into `instr_current`, and substitutes a NOP (14'h0000) on flush. Together with the decoder's 4-cycle Q sequence, this gives 4-cycle ordinary instructions and 8-cycle branches.

---
 rtl/pc_fetch_unit.sv | 120 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program counter, hardware return stack and instruction register for the
//   PIC16F core. Drives the program-memory address from the PC register,
//   captures the returned word into the instruction register, and loads a
//   NOP on flush so that a branch costs one extra instruction period.
//
// Ports
//   clk               core clock
//   rst               asynchronous reset, active low
//   pc_incr_en        PC <= PC + 1
//   pc_j_en           PC <= {pclath[4:3], IR[10:0]}            (goto)
//   pc_j_and_push_en  push PC, then jump as pc_j_en            (call)
//   pc_j_by_pop_en    PC <= popped stack entry                 (return)
//   instr_rd_en       IR <= prog_data
//   instr_flush       IR <= NOP, wins over instr_rd_en
//   pcl_wr_en         PC <= {pclath, pcl_wr_data}              (computed goto)
//   pcl_wr_data       byte written to PCL
//   pclath            PCLATH register contents
//   prog_data         program-memory word at prog_addr (combinational read)
//   prog_addr         current PC
//   instr_current     instruction register, feeds the decoder
//   pcl_rd            PC[7:0] for file-register reads of PCL
//   stack_ptr         stack pointer (next free slot), debug only
module pc_fetch_unit #(
    parameter int STACK_DEPTH = 8,
    parameter int PC_W        = 13
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_incr_en,
    input  logic            pc_j_en,
    input  logic            pc_j_and_push_en,
    input  logic            pc_j_by_pop_en,
    input  logic            instr_rd_en,
    input  logic            instr_flush,
    input  logic            pcl_wr_en,
    input  logic [7:0]      pcl_wr_data,
    input  logic [4:0]      pclath,
    input  logic [13:0]     prog_data,
    output logic [PC_W-1:0] prog_addr,
    output logic [13:0]     instr_current,
    output logic [7:0]      pcl_rd,
    output logic [2:0]      stack_ptr
);

    localparam int          SP_W = $clog2(STACK_DEPTH);
    localparam logic [13:0] NOP  = 14'h0000;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [13:0]     ir_q, ir_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic [SP_W-1:0] sp_dec;
    logic [PC_W-1:0] stack_q [STACK_DEPTH];
    logic [PC_W-1:0] jump_target;
    logic            push_en;

    // Goto/call target is formed from the IR value held before the edge, so
    // a flush on the same edge does not disturb it.
    assign jump_target = PC_W'({pclath[4:3], ir_q[10:0]});

    // Pointer arithmetic is modulo STACK_DEPTH: underflow and overflow wrap
    // silently, and an overflowing push overwrites the oldest entry.
    assign sp_dec = sp_q - SP_W'(1);

    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        push_en = 1'b0;
        if (pc_j_by_pop_en) begin
            sp_d = sp_dec;
            pc_d = stack_q[sp_dec];
        end else if (pc_j_and_push_en) begin
            push_en = 1'b1;
            sp_d    = sp_q + SP_W'(1);
            pc_d    = jump_target;
        end else if (pc_j_en) begin
            pc_d = jump_target;
        end else if (pcl_wr_en) begin
            pc_d = PC_W'({pclath, pcl_wr_data});
        end else if (pc_incr_en) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_comb begin
        ir_d = ir_q;
        if (instr_flush) begin
            ir_d = NOP;
        end else if (instr_rd_en) begin
            ir_d = prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= '0;
            ir_q <= NOP;
            sp_q <= '0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
            sp_q <= sp_d;
        end
    end

    // Stack storage has no reset; its contents are meaningless after reset.
    // The write is gated by rst so a push pending when reset hits is dropped.
    // At push time PC already holds the incremented return address.
    always_ff @(posedge clk) begin
        if (rst && push_en) begin
            stack_q[sp_q] <= pc_q;
        end
    end

    assign prog_addr     = pc_q;
    assign instr_current = ir_q;
    assign pcl_rd        = pc_q[7:0];
    assign stack_ptr     = 3'(sp_q);

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        pc_incr_en, pc_j_en, pc_j_and_push_en, pc_j_by_pop_en;
    logic        instr_rd_en, instr_flush, pcl_wr_en;
    logic [7:0]  pcl_wr_data;
    logic [4:0]  pclath;
    logic [13:0] prog_data;
    logic [12:0] prog_addr;
    logic [13:0] instr_current;
    logic [7:0]  pcl_rd;
    logic [2:0]  stack_ptr;

    int checks   = 0;
    int failures = 0;

    // op bits: {pcl_wr, flush, rd, pop, push, jump, incr}
    localparam logic [6:0] IDLE  = 7'b0000000;
    localparam logic [6:0] INCR  = 7'b0000001;
    localparam logic [6:0] FETCH = 7'b0010001;
    localparam logic [6:0] JFL   = 7'b0100010;
    localparam logic [6:0] CALLF = 7'b0100100;
    localparam logic [6:0] RETF  = 7'b0101000;
    localparam logic [6:0] PCLW  = 7'b1000000;

    typedef struct packed {
        logic [12:0] pc;
        logic [13:0] ir;
        logic [2:0]  sp;
    } exp_t;

    exp_t        sb [$];
    logic [13:0] mem [8192];
    logic [12:0] m_pc;
    logic [13:0] m_ir;
    logic [2:0]  m_sp;
    logic [12:0] m_stack [8];
    logic [12:0] ret [9];

    assign prog_data = mem[prog_addr];

    pc_fetch_unit #(.STACK_DEPTH(8), .PC_W(13)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_incr_en       (pc_incr_en),
        .pc_j_en          (pc_j_en),
        .pc_j_and_push_en (pc_j_and_push_en),
        .pc_j_by_pop_en   (pc_j_by_pop_en),
        .instr_rd_en      (instr_rd_en),
        .instr_flush      (instr_flush),
        .pcl_wr_en        (pcl_wr_en),
        .pcl_wr_data      (pcl_wr_data),
        .pclath           (pclath),
        .prog_data        (prog_data),
        .prog_addr        (prog_addr),
        .instr_current    (instr_current),
        .pcl_rd           (pcl_rd),
        .stack_ptr        (stack_ptr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        pc_incr_en = 0; pc_j_en = 0; pc_j_and_push_en = 0; pc_j_by_pop_en = 0;
        instr_rd_en = 0; instr_flush = 0; pcl_wr_en = 0; pcl_wr_data = 8'h00;
    endtask

    // Drives one clock of controls, predicts the result and queues it.
    task automatic cycle(input logic [6:0] op, input logic [7:0] pd);
        exp_t        e;
        logic [12:0] tgt;
        @(negedge clk);
        {pcl_wr_en, instr_flush, instr_rd_en, pc_j_by_pop_en,
         pc_j_and_push_en, pc_j_en, pc_incr_en} = op;
        pcl_wr_data = pd;
        tgt  = {pclath[4:3], m_ir[10:0]};
        e.ir = op[5] ? 14'h0000 : (op[4] ? mem[m_pc] : m_ir);
        if (op[3]) begin
            m_sp = m_sp - 3'd1;
            m_pc = m_stack[m_sp];
        end else if (op[2]) begin
            m_stack[m_sp] = m_pc;
            m_sp = m_sp + 3'd1;
            m_pc = tgt;
        end else if (op[1]) begin
            m_pc = tgt;
        end else if (op[6]) begin
            m_pc = {pclath, pd};
        end else if (op[0]) begin
            m_pc = m_pc + 13'd1;
        end
        m_ir = e.ir;
        e.pc = m_pc;
        e.sp = m_sp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        pclath = 5'h00;
        m_pc = '0; m_ir = '0; m_sp = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (prog_addr !== 13'h0 || instr_current !== 14'h0 || stack_ptr !== 3'd0 || pcl_rd !== 8'h0) begin
            failures++;
            $display("FAIL reset: pc=%h ir=%h sp=%0d pcl=%h want all zero",
                     prog_addr, instr_current, stack_ptr, pcl_rd);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fetch();
        exp_t        e;
        logic [13:0] want [3];
        want[0] = 14'h3005; want[1] = 14'h3E01; want[2] = 14'h0000;
        for (int p = 0; p < 3; p++) begin
            for (int q = 0; q < 4; q++) begin
                cycle((q == 2) ? FETCH : IDLE, 8'h00);
                e = sb.pop_front();
                checks++;
                if (prog_addr !== e.pc || instr_current !== e.ir || stack_ptr !== e.sp) begin
                    failures++;
                    $display("FAIL fetch_sb: pc=%h ir=%h sp=%0d want pc=%h ir=%h sp=%0d",
                             prog_addr, instr_current, stack_ptr, e.pc, e.ir, e.sp);
                end
            end
            checks++;
            if (instr_current !== want[p] || prog_addr !== 13'(p + 1)) begin
                failures++;
                $display("FAIL fetch_seq%0d: ir=%h pc=%h want ir=%h pc=%h",
                         p, instr_current, prog_addr, want[p], 13'(p + 1));
            end
        end
    endtask

    task automatic test_goto();
        exp_t        e;
        logic [6:0]  ops [8];
        pclath = 5'b01000;
        ops = '{IDLE, IDLE, FETCH, IDLE, IDLE, IDLE, IDLE, JFL};
        for (int i = 0; i < 8; i++) begin
            cycle(ops[i], 8'h00);
            e = sb.pop_front();
            checks++;
            if (prog_addr !== e.pc || instr_current !== e.ir || stack_ptr !== e.sp) begin
                failures++;
                $display("FAIL goto_sb%0d: pc=%h ir=%h sp=%0d want pc=%h ir=%h sp=%0d",
                         i, prog_addr, instr_current, stack_ptr, e.pc, e.ir, e.sp);
            end
        end
        checks++;
        if (prog_addr !== 13'h0ABC || instr_current !== 14'h0000) begin
            failures++;
            $display("FAIL goto_target: pc=%h ir=%h want pc=0abc ir=0000", prog_addr, instr_current);
        end
        cycle(FETCH, 8'h00);
        e = sb.pop_front();
        checks++;
        if (instr_current !== 14'h1234 || prog_addr !== 13'h0ABD || instr_current !== e.ir) begin
            failures++;
            $display("FAIL goto_fetch: ir=%h pc=%h want ir=1234 pc=0abd", instr_current, prog_addr);
        end
    endtask

    task automatic test_call_return();
        exp_t        e;
        logic [6:0]  ops [4];
        logic [12:0] want_pc [4];
        logic [2:0]  want_sp [4];
        pclath = 5'h00;
        cycle(PCLW, 8'h10);
        e = sb.pop_front();
        checks++;
        if (prog_addr !== e.pc || prog_addr !== 13'h010) begin
            failures++;
            $display("FAIL call_setup: pc=%h want 010", prog_addr);
        end
        ops     = '{FETCH, CALLF, FETCH, RETF};
        want_pc = '{13'h011, 13'h100, 13'h101, 13'h011};
        want_sp = '{3'd0, 3'd1, 3'd1, 3'd0};
        for (int i = 0; i < 4; i++) begin
            cycle(ops[i], 8'h00);
            e = sb.pop_front();
            checks++;
            if (prog_addr !== want_pc[i] || stack_ptr !== want_sp[i] || instr_current !== e.ir) begin
                failures++;
                $display("FAIL call_ret%0d: pc=%h sp=%0d ir=%h want pc=%h sp=%0d ir=%h",
                         i, prog_addr, stack_ptr, instr_current, want_pc[i], want_sp[i], e.ir);
            end
        end
    endtask

    task automatic test_nested_wrap();
        exp_t        e;
        logic [12:0] want;
        pclath = 5'h04;
        cycle(PCLW, 8'h00);
        void'(sb.pop_front());
        pclath = 5'h00;
        for (int i = 0; i < 9; i++) begin
            cycle(FETCH, 8'h00);
            void'(sb.pop_front());
            ret[i] = m_pc;
            cycle(CALLF, 8'h00);
            e = sb.pop_front();
            checks++;
            if (stack_ptr !== 3'((i + 1) % 8) || prog_addr !== e.pc) begin
                failures++;
                $display("FAIL push%0d: sp=%0d pc=%h want sp=%0d pc=%h",
                         i, stack_ptr, prog_addr, (i + 1) % 8, e.pc);
            end
        end
        for (int k = 1; k <= 10; k++) begin
            cycle(RETF, 8'h00);
            e = sb.pop_front();
            if (k == 1 || k == 9) want = ret[8];
            else if (k == 10)     want = ret[7];
            else                  want = ret[9 - k];
            checks++;
            if (prog_addr !== want || stack_ptr !== e.sp || instr_current !== 14'h0) begin
                failures++;
                $display("FAIL pop%0d: pc=%h sp=%0d want pc=%h sp=%0d",
                         k, prog_addr, stack_ptr, want, e.sp);
            end
        end
        checks++;
        if (stack_ptr !== 3'd7) begin
            failures++;
            $display("FAIL underflow: sp=%0d want 7", stack_ptr);
        end
    endtask

    task automatic test_pcl_and_wrap();
        exp_t e;
        pclath = 5'h03;
        cycle(PCLW, 8'h40);
        void'(sb.pop_front());
        checks++;
        if (prog_addr !== 13'h340) begin
            failures++;
            $display("FAIL pcl_write: pc=%h want 340", prog_addr);
        end
        cycle(FETCH, 8'h00);
        e = sb.pop_front();
        checks++;
        if (prog_addr !== 13'h341 || pcl_rd !== 8'h41 || instr_current !== 14'h0F55 || e.ir !== 14'h0F55) begin
            failures++;
            $display("FAIL pcl_fetch: pc=%h pcl=%h ir=%h want pc=341 pcl=41 ir=0f55",
                     prog_addr, pcl_rd, instr_current);
        end
        pclath = 5'h1F;
        cycle(PCLW, 8'hFF);
        void'(sb.pop_front());
        cycle(INCR, 8'h00);
        e = sb.pop_front();
        checks++;
        if (prog_addr !== 13'h0000 || e.pc !== 13'h0000) begin
            failures++;
            $display("FAIL pc_wrap: pc=%h want 0000", prog_addr);
        end
        pclath = 5'h00;
    endtask

    task automatic test_priority();
        exp_t e;
        // state: sp = 7 after underflow
        cycle(7'b0001100, 8'h00);
        e = sb.pop_front();
        checks++;
        if (stack_ptr !== 3'd6 || prog_addr !== e.pc || prog_addr !== ret[6]) begin
            failures++;
            $display("FAIL pop_over_push: sp=%0d pc=%h want sp=6 pc=%h", stack_ptr, prog_addr, ret[6]);
        end
        cycle(FETCH, 8'h00);
        void'(sb.pop_front());
        cycle(7'b0110000, 8'h00);
        e = sb.pop_front();
        checks++;
        if (instr_current !== 14'h0000 || prog_addr !== e.pc) begin
            failures++;
            $display("FAIL flush_over_rd: ir=%h pc=%h want ir=0000 pc=%h", instr_current, prog_addr, e.pc);
        end
        cycle(7'b1000011, 8'h77);
        e = sb.pop_front();
        checks++;
        if (prog_addr !== e.pc || stack_ptr !== 3'd6) begin
            failures++;
            $display("FAIL jump_over_pcl: pc=%h sp=%0d want pc=%h sp=6", prog_addr, stack_ptr, e.pc);
        end
    endtask

    task automatic test_reset_mid_call();
        exp_t e;
        cycle(IDLE, 8'h00);
        void'(sb.pop_front());
        pc_j_and_push_en = 1'b1;
        instr_flush      = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (prog_addr !== 13'h0 || stack_ptr !== 3'd0 || instr_current !== 14'h0) begin
            failures++;
            $display("FAIL async_reset: pc=%h sp=%0d ir=%h want all zero",
                     prog_addr, stack_ptr, instr_current);
        end
        @(posedge clk);
        #1;
        checks++;
        if (prog_addr !== 13'h0 || stack_ptr !== 3'd0) begin
            failures++;
            $display("FAIL reset_hold: pc=%h sp=%0d want 0/0", prog_addr, stack_ptr);
        end
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        m_pc = '0; m_ir = '0; m_sp = '0;
        cycle(FETCH, 8'h00);
        e = sb.pop_front();
        checks++;
        if (instr_current !== 14'h3005 || prog_addr !== 13'h001 || stack_ptr !== 3'd0 || e.ir !== 14'h3005) begin
            failures++;
            $display("FAIL post_reset_fetch: ir=%h pc=%h sp=%0d want ir=3005 pc=001 sp=0",
                     instr_current, prog_addr, stack_ptr);
        end
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) begin
            mem[a] = 14'h2000 | 14'((a + 32) % 2048);
        end
        mem[0]      = 14'h3005;
        mem[1]      = 14'h3E01;
        mem[2]      = 14'h0000;
        mem[3]      = 14'h2ABC;
        mem[13'hABC] = 14'h1234;
        mem[13'h010] = 14'h2100;
        mem[13'h100] = 14'h0008;
        mem[13'h340] = 14'h0F55;

        test_reset();
        test_fetch();
        test_goto();
        test_call_return();
        test_nested_wrap();
        test_pcl_and_wrap();
        test_priority();
        test_reset_mid_call();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
